bcd_seg7_scanner: RTL and testbench

- Drives a 3‑digit multiplexed common‑anode seven‑segment display from the 12‑bit packed BCD word produced by the binary‑to‑BCD converter (`{hundreds, tens, units}`).
- A `load` strobe latches each new word into a shadow register; the displayed value changes only at frame boundaries, so no frame shows a mix of old and new digits.
- Scans digits with a programmable refresh divider and an all‑off guard interval between digits to suppress ghosting.
- Blanks leading zeros and shows `E` for any non‑decimal nibble.

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_decoder.sv | 37 +++
 rtl/bcd_seg7_scanner.sv | 132 +++++++++++++
 tb/tb_bcd_seg7_scanner.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_pkg                                                             |
// | Segment patterns (active-low {g,f,e,d,c,b,a}) and scan-state codes.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package seg7_pkg;

    typedef enum logic [0:0] {
        ST_SHOW  = 1'b0,
        ST_GUARD = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_decoder                                                         |
// | Combinational BCD nibble to active-low segment pattern, with blank.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_E;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else begin
            case (nibble_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_E;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_seg7_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_seg7_scanner                                                     |
// | 3-digit multiplexed common-anode scanner with frame-aligned update.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bcd_seg7_scanner
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bcd,
    input  logic        load,
    output logic [2:0]  an,
    output logic [6:0]  seg,
    output logic        frame_tick
);

    localparam int c_cnt_max = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_show_last  = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_guard_last = c_cnt_w'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    scan_state_t        state_q;
    logic [c_cnt_w-1:0] cnt_q;
    logic [1:0]         idx_q;
    logic [11:0]        pending_q;
    logic [11:0]        active_q;
    logic [2:0]         an_q;
    logic [6:0]         seg_q;
    logic               frame_tick_q;

    logic [1:0]         idx_d;
    logic               w_wrap;
    logic [3:0]         w_nibble;
    logic               w_blank;
    logic [6:0]         w_seg;

    always_comb begin
        w_wrap   = (idx_q == 2'd2);
        idx_d    = w_wrap ? 2'd0 : idx_q + 2'd1;
        w_nibble = active_q[3:0];
        w_blank  = 1'b0;
        case (idx_q)
            2'd1: begin
                w_nibble = active_q[7:4];
                w_blank  = (active_q[11:4] == 8'h00);
            end
            2'd2: begin
                w_nibble = active_q[11:8];
                w_blank  = (active_q[11:8] == 4'h0);
            end
            default: ;
        endcase
    end

    seg7_decoder u_dec (
        .nibble_i (w_nibble),
        .blank_i  (w_blank),
        .seg_o    (w_seg)
    );

    // Digit advance also closes the frame when idx wraps: active takes the
    // pre-edge pending value, so a load on this edge waits a whole frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_SHOW;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            pending_q    <= 12'h000;
            active_q     <= 12'h000;
            an_q         <= 3'b111;
            seg_q        <= SEG_BLANK;
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= 1'b0;
            if (load) begin
                pending_q <= bcd;
            end

            case (state_q)
                ST_SHOW: begin
                    if (cnt_q == c_show_last) begin
                        cnt_q <= '0;
                        if (BLANK_CYCLES == 0) begin
                            idx_q <= idx_d;
                            if (w_wrap) begin
                                active_q     <= pending_q;
                                frame_tick_q <= 1'b1;
                            end
                        end else begin
                            state_q <= ST_GUARD;
                        end
                    end else begin
                        cnt_q <= cnt_q + c_cnt_w'(1);
                    end
                end
                ST_GUARD: begin
                    if (cnt_q == c_guard_last) begin
                        cnt_q   <= '0;
                        state_q <= ST_SHOW;
                        idx_q   <= idx_d;
                        if (w_wrap) begin
                            active_q     <= pending_q;
                            frame_tick_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + c_cnt_w'(1);
                    end
                end
                default: state_q <= ST_SHOW;
            endcase

            if (state_q == ST_SHOW) begin
                an_q  <= ~(3'b001 << idx_q);
                seg_q <= w_seg;
            end else begin
                an_q  <= 3'b111;
                seg_q <= SEG_BLANK;
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seg7_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bcd_seg7_scanner                                                  |
// | Two scanner instances (guard 1 and guard 0) against a timeline model.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_bcd_seg7_scanner;

    localparam int R  = 4;
    localparam int B0 = 1;
    localparam int B1 = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] bcd = 12'h000;
    logic        load = 1'b0;
    logic [2:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        ft0, ft1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bcd_seg7_scanner #(.REFRESH_DIV(R), .BLANK_CYCLES(B0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .load(load),
        .an(an0), .seg(seg0), .frame_tick(ft0)
    );

    bcd_seg7_scanner #(.REFRESH_DIV(R), .BLANK_CYCLES(B1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .load(load),
        .an(an1), .seg(seg1), .frame_tick(ft1)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] digit_seg(input logic [11:0] v, input int d);
        logic [6:0] tbl [10];
        logic [3:0] nib;
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        nib = 4'((v >> (4 * d)) & 12'hF);
        if (d == 2 && v[11:8] == 4'h0) return 7'h7F;
        if (d == 1 && v[11:4] == 8'h00) return 7'h7F;
        if (nib > 4'd9) return 7'h06;
        return tbl[nib];
    endfunction

    // Output after edge k is what the display must show at time k of the
    // scan timeline: digit period r+b, lit for the first r cycles.
    task automatic model_out(input int k, input logic [11:0] v, input int r, input int b,
                             output logic [2:0] a, output logic [6:0] s);
        int p, d, o;
        p = r + b;
        d = (k / p) % 3;
        o = k % p;
        a = 3'b111;
        s = 7'h7F;
        if (o < r) begin
            a[d] = 1'b0;
            s = digit_seg(v, d);
        end
    endtask

    int          k0 = 0, k1 = 0;
    logic [11:0] pend = 12'h000, act0 = 12'h000, act1 = 12'h000;
    logic [2:0]  e_an0, e_an1;
    logic [6:0]  e_seg0, e_seg1;
    logic        e_ft0, e_ft1;
    logic        model_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            k0 = 0; k1 = 0;
            pend = 12'h000; act0 = 12'h000; act1 = 12'h000;
            e_an0 = 3'b111; e_seg0 = 7'h7F; e_ft0 = 1'b0;
            e_an1 = 3'b111; e_seg1 = 7'h7F; e_ft1 = 1'b0;
        end else begin
            model_out(k0, act0, R, B0, e_an0, e_seg0);
            model_out(k1, act1, R, B1, e_an1, e_seg1);
            e_ft0 = ((k0 + 1) % (3 * (R + B0))) == 0;
            e_ft1 = ((k1 + 1) % (3 * (R + B1))) == 0;
            if (e_ft0) act0 = pend;
            if (e_ft1) act1 = pend;
            if (load) pend = bcd;
            k0++; k1++;
        end
        model_valid = 1'b1;
    end

    function automatic logic an_ok(input logic [2:0] a);
        return (a == 3'b111) || (a == 3'b110) || (a == 3'b101) || (a == 3'b011);
    endfunction

    always @(negedge clk) begin
        if (model_valid) begin
            chk("an0", {13'd0, an0}, {13'd0, e_an0});
            chk("seg0", {9'd0, seg0}, {9'd0, e_seg0});
            chk("ft0", {15'd0, ft0}, {15'd0, e_ft0});
            chk("an1", {13'd0, an1}, {13'd0, e_an1});
            chk("seg1", {9'd0, seg1}, {9'd0, e_seg1});
            chk("ft1", {15'd0, ft1}, {15'd0, e_ft1});
            chk("overlap0", {15'd0, an_ok(an0)}, 16'd1);
            chk("overlap1", {15'd0, an_ok(an1)}, 16'd1);
        end
    end

    task automatic pulse_load(input logic [11:0] v);
        bcd = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_ft0(input string name);
        int n;
        n = 0;
        while (!ft0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ft0) chk({name, "_timeout"}, 16'd0, 16'd1);
    endtask

    // Records what each digit shows over the frame following a frame_tick.
    task automatic capture_frame(input string name, output logic [6:0] h, output logic [6:0] t,
                                 output logic [6:0] u);
        h = 7'h55; t = 7'h55; u = 7'h55;
        wait_ft0(name);
        for (int i = 0; i < 3 * (R + B0); i++) begin
            @(negedge clk);
            case (an0)
                3'b110: u = seg0;
                3'b101: t = seg0;
                3'b011: h = seg0;
                default: ;
            endcase
        end
    endtask

    task automatic expect_frame(input string name, input logic [6:0] eh, input logic [6:0] et,
                                input logic [6:0] eu);
        logic [6:0] h, t, u;
        capture_frame(name, h, t, u);
        chk({name, "_hund"}, {9'd0, h}, {9'd0, eh});
        chk({name, "_tens"}, {9'd0, t}, {9'd0, et});
        chk({name, "_units"}, {9'd0, u}, {9'd0, eu});
    endtask

    initial begin
        int n;
        logic [6:0] h, t, u;

        repeat (3) @(negedge clk);
        chk("rst_an", {13'd0, an0}, 16'h0007);
        chk("rst_seg", {9'd0, seg0}, 16'h007F);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_an", {13'd0, an0}, 16'h0006);
        chk("first_seg", {9'd0, seg0}, 16'h0040);
        n = 1;
        while (!ft0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("first_tick", 16'(n), 16'd15);

        // Load mid-frame: old value holds through the current frame.
        repeat (3) @(negedge clk);
        pulse_load(12'h255);
        chk("hold_old", {9'd0, seg0 | 7'h00}, {9'd0, seg0 === 7'h40 || seg0 === 7'h7F ? seg0 : 7'h40});
        expect_frame("load255", 7'h24, 7'h12, 7'h12);

        pulse_load(12'h111);
        repeat (2) @(negedge clk);
        pulse_load(12'h222);
        expect_frame("last_wins", 7'h24, 7'h24, 7'h24);

        pulse_load(12'h007);
        expect_frame("blank007", 7'h7F, 7'h7F, 7'h78);
        pulse_load(12'h070);
        expect_frame("blank070", 7'h7F, 7'h78, 7'h40);
        pulse_load(12'h000);
        expect_frame("blank000", 7'h7F, 7'h7F, 7'h40);
        pulse_load(12'h1A3);
        expect_frame("invalid", 7'h79, 7'h06, 7'h30);

        // Load on the boundary edge is deferred by one frame.
        n = 0;
        while (k0 % 15 != 14 && n < 100) begin
            @(negedge clk);
            n++;
        end
        pulse_load(12'h345);
        capture_frame("boundary_old", h, t, u);
        chk("boundary_old_units", {9'd0, u}, 16'h0030);
        expect_frame("boundary_new", 7'h30, 7'h19, 7'h12);

        // Reset during the guard after digit 1.
        n = 0;
        while (k0 % 15 != 9 && n < 100) begin
            @(negedge clk);
            n++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk("guard_rst_an", {13'd0, an0}, 16'h0007);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_an", {13'd0, an0}, 16'h0006);
        chk("restart_seg", {9'd0, seg0}, 16'h0040);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0) begin
                bcd = 12'($urandom);
                if ($urandom_range(2) == 0) bcd[11:4] = 8'h00;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            rst_n = ($urandom_range(299) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        load = 1'b0;
        repeat (40) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
